processor: RTL and testbench

- Small 24-bit multi-cycle ASIP core: instruction ROM, 16-entry register file, data RAM, ALU with multiply and iterative divide, conditional branch.
- Exposes PC, current instruction, last result and a 64-bit retire trace word with valid strobe for board-level logging.
- Top-level DUT.

---
 rtl/processor.sv | 196 +++++++++++++++++++
 tb/tb_processor.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/processor.sv
// ---------------------------------------------------------------------------
// processor : 24-bit multi-cycle ASIP core (ROM, 16x24 regfile, data RAM,
//             multiply, iterative restoring divide, conditional branch)
// Revision  : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module processor #(
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 256,
  parameter int DIV_CYCLES = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  btn,
  output logic [15:0] pc,
  output logic [23:0] inst,
  output logic [47:0] result,
  output logic [63:0] data,
  output logic        enable
);

  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);
  localparam int CW  = $clog2(DIV_CYCLES);

  localparam logic [3:0] c_OP_MULT  = 4'b0000;
  localparam logic [3:0] c_OP_MULTI = 4'b0001;
  localparam logic [3:0] c_OP_DIV   = 4'b0011;
  localparam logic [3:0] c_OP_ADD   = 4'b0100;
  localparam logic [3:0] c_OP_LDR   = 4'b0101;
  localparam logic [3:0] c_OP_STR   = 4'b0110;
  localparam logic [3:0] c_OP_BCND  = 4'b1000;
  localparam logic [3:0] c_OP_ADDI  = 4'b1111;

  localparam logic [23:0] c_NOP = 24'h700000;
  localparam logic [23:0] c_ROM [0:7] = '{
    24'hF66060, 24'h066600, 24'h166004, 24'h570001,
    24'h670001, 24'h311003, 24'h432100, 24'h806511
  };

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_DIVW   = 3'd3,
    S_WB     = 3'd4
  } state_t;

  state_t       r_state;
  logic [15:0]  r_pc;
  logic [23:0]  r_inst;
  logic [47:0]  r_result;
  logic [63:0]  r_data;
  logic         r_enable;
  logic [23:0]  r_a;
  logic [23:0]  r_b;
  logic [23:0]  r_d;
  logic [47:0]  r_alu;
  logic         r_taken;
  logic [23:0]  r_div_rem;
  logic [23:0]  r_div_quo;
  logic [CW-1:0] r_div_cnt;
  logic [23:0]  r_regs [16];
  logic [23:0]  r_dmem [DMEM_DEPTH];

  logic [3:0]     w_op;
  logic [3:0]     w_rd;
  logic [3:0]     w_rn;
  logic [3:0]     w_rm;
  logic [23:0]    w_imm;
  logic [DAW-1:0] w_daddr;
  logic [IAW-1:0] w_iaddr;
  logic [23:0]    w_rom_word;
  logic [24:0]    w_div_shift;
  logic [25:0]    w_div_sub;
  logic           w_div_ok;
  logic [23:0]    w_rem_next;
  logic [23:0]    w_quo_next;
  logic           w_unused;

  assign w_op    = r_inst[23:20];
  assign w_rd    = r_inst[19:16];
  assign w_rn    = r_inst[15:12];
  assign w_rm    = r_inst[11:8];
  assign w_imm   = {12'd0, r_inst[11:0]};
  assign w_daddr = r_inst[DAW-1:0];
  assign w_iaddr = r_pc[IAW-1:0];
  assign w_rom_word = (w_iaddr < IAW'(8)) ? c_ROM[w_iaddr[2:0]] : c_NOP;

  // One restoring-division step; a zero divisor naturally yields all-ones.
  assign w_div_shift = {r_div_rem, r_div_quo[23]};
  assign w_div_sub   = {1'b0, w_div_shift} - {2'b00, r_b};
  assign w_div_ok    = ~w_div_sub[25];
  assign w_rem_next  = w_div_ok ? w_div_sub[23:0] : w_div_shift[23:0];
  assign w_quo_next  = {r_div_quo[22:0], w_div_ok};

  assign w_unused = ^btn[3:1];

  assign pc     = r_pc;
  assign inst   = r_inst;
  assign result = r_result;
  assign data   = r_data;
  assign enable = r_enable;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_pc      <= '0;
      r_inst    <= '0;
      r_result  <= '0;
      r_data    <= '0;
      r_enable  <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_d       <= '0;
      r_alu     <= '0;
      r_taken   <= 1'b0;
      r_div_rem <= '0;
      r_div_quo <= '0;
      r_div_cnt <= '0;
      for (int i = 0; i < 16; i++)
        r_regs[i] <= (i == 1) ? 24'd30 : (i == 2) ? 24'd48 : 24'd0;
      for (int i = 0; i < DMEM_DEPTH; i++)
        r_dmem[i] <= (i == 1) ? 24'd15 : 24'd0;
    end else if (!btn[0]) begin
      r_enable <= 1'b0;
    end else begin
      r_enable <= 1'b0;
      case (r_state)
        S_FETCH: begin
          r_inst  <= w_rom_word;
          r_state <= S_DECODE;
        end
        S_DECODE: begin
          r_a     <= r_regs[w_rn];
          r_b     <= r_regs[w_rm];
          r_d     <= r_regs[w_rd];
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_state <= S_WB;
          r_taken <= 1'b0;
          case (w_op)
            c_OP_MULT:  r_alu <= 48'(r_a) * 48'(r_b);
            c_OP_MULTI: r_alu <= 48'(r_a) * 48'(w_imm);
            c_OP_ADD:   r_alu <= {24'd0, r_a + r_b};
            c_OP_ADDI:  r_alu <= {24'd0, r_a + w_imm};
            c_OP_LDR:   r_alu <= {24'd0, r_dmem[w_daddr]};
            c_OP_STR:   r_alu <= {24'd0, r_d};
            c_OP_BCND: begin
              r_alu   <= {40'd0, r_inst[7:0]};
              r_taken <= (r_a != r_b);
            end
            c_OP_DIV: begin
              r_b       <= w_imm;
              r_div_rem <= '0;
              r_div_quo <= r_a;
              r_div_cnt <= CW'(DIV_CYCLES - 1);
              r_state   <= S_DIVW;
            end
            default:    r_alu <= r_result;
          endcase
        end
        S_DIVW: begin
          r_div_rem <= w_rem_next;
          r_div_quo <= w_quo_next;
          r_div_cnt <= r_div_cnt - CW'(1);
          if (r_div_cnt == '0) begin
            r_alu   <= {24'd0, w_quo_next};
            r_state <= S_WB;
          end
        end
        S_WB: begin
          case (w_op)
            c_OP_MULT, c_OP_MULTI, c_OP_DIV, c_OP_ADD, c_OP_LDR, c_OP_ADDI:
              r_regs[w_rd] <= r_alu[23:0];
            c_OP_STR:
              r_dmem[w_daddr] <= r_d;
            default: ;
          endcase
          r_pc     <= r_taken ? {8'd0, r_inst[7:0]} : r_pc + 16'd1;
          r_result <= r_alu;
          r_data   <= {r_pc, r_inst, r_alu[23:0]};
          r_enable <= 1'b1;
          r_taken  <= 1'b0;
          r_state  <= S_FETCH;
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_processor.sv
// ---------------------------------------------------------------------------
// tb_processor : directed self-checking bench for processor
// Revision     : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_processor;

  logic        clk;
  logic        rst;
  logic [3:0]  btn;
  logic [15:0] pc;
  logic [23:0] inst;
  logic [47:0] result;
  logic [63:0] data;
  logic        enable;

  int checks;
  int failures;

  processor dut (
    .clk    (clk),
    .rst    (rst),
    .btn    (btn),
    .pc     (pc),
    .inst   (inst),
    .result (result),
    .data   (data),
    .enable (enable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_count(input int n, output int pulses);
    pulses = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (enable) pulses++;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    btn = 4'b0001;
    @(posedge clk);
    #1;
    checks++; if (pc !== 16'd0) begin failures++; $display("FAIL reset_pc got %h want %h", pc, 16'd0); end
    checks++; if (inst !== 24'd0) begin failures++; $display("FAIL reset_inst got %h want %h", inst, 24'd0); end
    checks++; if (result !== 48'd0) begin failures++; $display("FAIL reset_result got %h want %h", result, 48'd0); end
    checks++; if (data !== 64'd0) begin failures++; $display("FAIL reset_data got %h want %h", data, 64'd0); end
    checks++; if (enable !== 1'b0) begin failures++; $display("FAIL reset_enable got %b want 0", enable); end
    rst = 1'b0;
  endtask

  task automatic test_arith();
    int p;
    run_count(3, p);
    checks++; if (p !== 0) begin failures++; $display("FAIL addi_early_enable got %0d want 0", p); end
    step(1);
    checks++; if (enable !== 1'b1) begin failures++; $display("FAIL addi_enable got %b want 1", enable); end
    checks++; if (result !== 48'd96) begin failures++; $display("FAIL addi_result got %0d want 96", result); end
    checks++; if (pc !== 16'd1) begin failures++; $display("FAIL addi_pc got %0d want 1", pc); end
    checks++; if (data !== {16'd0, 24'hF66060, 24'd96}) begin failures++; $display("FAIL addi_data got %h want %h", data, {16'd0, 24'hF66060, 24'd96}); end
    step(1);
    checks++; if (enable !== 1'b0) begin failures++; $display("FAIL enable_one_cycle got %b want 0", enable); end
    step(3);
    checks++; if (result !== 48'd9216) begin failures++; $display("FAIL mult_result got %0d want 9216", result); end
    step(4);
    checks++; if (result !== 48'd36864) begin failures++; $display("FAIL multi_result got %0d want 36864", result); end
    checks++; if (pc !== 16'd3) begin failures++; $display("FAIL multi_pc got %0d want 3", pc); end
  endtask

  task automatic test_ldr_str();
    step(4);
    checks++; if (result !== 48'd15) begin failures++; $display("FAIL ldr_result got %0d want 15", result); end
    step(4);
    checks++; if (result !== 48'd15) begin failures++; $display("FAIL str_result got %0d want 15", result); end
    checks++; if (pc !== 16'd5) begin failures++; $display("FAIL str_pc got %0d want 5", pc); end
  endtask

  task automatic test_div();
    int p;
    run_count(27, p);
    checks++; if (p !== 0) begin failures++; $display("FAIL div_early_enable got %0d want 0", p); end
    checks++; if (pc !== 16'd5) begin failures++; $display("FAIL div_pc_hold got %0d want 5", pc); end
    step(1);
    checks++; if (enable !== 1'b1) begin failures++; $display("FAIL div_enable got %b want 1", enable); end
    checks++; if (result !== 48'd10) begin failures++; $display("FAIL div_result got %0d want 10", result); end
    checks++; if (pc !== 16'd6) begin failures++; $display("FAIL div_pc got %0d want 6", pc); end
  endtask

  task automatic test_add();
    step(4);
    checks++; if (result !== 48'd58) begin failures++; $display("FAIL add_result got %0d want 58", result); end
  endtask

  task automatic test_bcnd();
    step(4);
    checks++; if (result !== 48'd17) begin failures++; $display("FAIL bcnd_result got %0d want 17", result); end
    checks++; if (pc !== 16'd17) begin failures++; $display("FAIL bcnd_pc got %0d want 17", pc); end
    checks++; if (data !== {16'd7, 24'h806511, 24'd17}) begin failures++; $display("FAIL bcnd_data got %h want %h", data, {16'd7, 24'h806511, 24'd17}); end
    step(4);
    checks++; if (enable !== 1'b1) begin failures++; $display("FAIL nop_enable got %b want 1", enable); end
    checks++; if (result !== 48'd17) begin failures++; $display("FAIL nop_result got %0d want 17", result); end
    checks++; if (pc !== 16'd18) begin failures++; $display("FAIL nop_pc got %0d want 18", pc); end
    checks++; if (inst !== 24'h700000) begin failures++; $display("FAIL nop_inst got %h want 700000", inst); end
  endtask

  task automatic test_freeze_div();
    int p;
    apply_reset();
    run_count(28, p);
    btn = 4'b0000;
    run_count(10, p);
    checks++; if (p !== 0) begin failures++; $display("FAIL freeze_enable got %0d want 0", p); end
    checks++; if (pc !== 16'd5) begin failures++; $display("FAIL freeze_pc got %0d want 5", pc); end
    checks++; if (inst !== 24'h311003) begin failures++; $display("FAIL freeze_inst got %h want 311003", inst); end
    btn = 4'b0001;
    run_count(19, p);
    checks++; if (p !== 0) begin failures++; $display("FAIL resume_early_enable got %0d want 0", p); end
    step(1);
    checks++; if (enable !== 1'b1) begin failures++; $display("FAIL resume_enable got %b want 1", enable); end
    checks++; if (result !== 48'd10) begin failures++; $display("FAIL resume_div_result got %0d want 10", result); end
  endtask

  task automatic test_reset_mid_mult();
    int p;
    apply_reset();
    step(6);
    #3;
    rst = 1'b1;
    #1;
    checks++; if (pc !== 16'd0) begin failures++; $display("FAIL async_pc got %h want 0", pc); end
    checks++; if (result !== 48'd0) begin failures++; $display("FAIL async_result got %h want 0", result); end
    checks++; if (data !== 64'd0) begin failures++; $display("FAIL async_data got %h want 0", data); end
    checks++; if (inst !== 24'd0) begin failures++; $display("FAIL async_inst got %h want 0", inst); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_count(3, p);
    checks++; if (p !== 0) begin failures++; $display("FAIL restart_early_enable got %0d want 0", p); end
    step(1);
    checks++; if (result !== 48'd96) begin failures++; $display("FAIL restart_result got %0d want 96", result); end
    checks++; if (pc !== 16'd1) begin failures++; $display("FAIL restart_pc got %0d want 1", pc); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    btn      = 4'b0001;
    test_reset();
    test_arith();
    test_ldr_str();
    test_div();
    test_add();
    test_bcnd();
    test_freeze_div();
    test_reset_mid_mult();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
